pram_arbiter: RTL and testbench

Two-requester arbiter sharing the single-port, byte-writable program/data RAM (`pram`) between the instruction-fetch port (P0) and the load/store port (P1). Grants at most one access per cycle using round-robin on contention, drives the RAM's CE/ADDR/WDATA/WE, and routes the RAM's one-cycle-latency read data and valid back to the requester that issued the access.

---
 rtl/pram_arb_pkg.sv | 22 ++
 rtl/pram_arb_rr.sv | 34 +++
 rtl/pram_arbiter.sv | 160 ++++++++++++++++
 tb/tb_pram_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pram_arb_pkg.sv
// Shared types and helpers for the pram arbiter slice.
// Port identifiers and the byte-lane / word-shift arithmetic used by both
// the round-robin picker and the arbiter top.
package pram_arb_pkg;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } port_id_t;

    // Byte lanes per data word.
    function automatic int unsigned n_cols(input int unsigned data_width,
                                           input int unsigned byte_width);
        return data_width / byte_width;
    endfunction

    // Right shift that turns a byte address into a word index.
    function automatic int unsigned word_shift(input int unsigned cols);
        return $clog2(cols);
    endfunction

endpackage

// File: rtl/pram_arb_rr.sv
// Two-input round-robin picker.
// Holds the last-granted port; on contention the other port wins.
// Reset leaves PORT_LS as last-granted so PORT_IF wins the first contention.
module pram_arb_rr
    import pram_arb_pkg::*;
(
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic [1:0] i_REQ,
    output logic [1:0] o_GNT
);

    port_id_t lg;

    // One-hot grant from the current requests and the last-granted port.
    always_comb begin
        o_GNT = i_REQ;
        if (i_REQ == 2'b11) begin
            o_GNT = (lg == PORT_LS) ? 2'b01 : 2'b10;
        end
    end

    // Remember which port was served last.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            lg <= PORT_LS;
        end else if (o_GNT[0]) begin
            lg <= PORT_IF;
        end else if (o_GNT[1]) begin
            lg <= PORT_LS;
        end
    end

endmodule

// File: rtl/pram_arbiter.sv
// Arbiter sharing the single-port program/data RAM between instruction fetch
// (P0) and load/store (P1). One access per cycle, round-robin on contention,
// read data routed back to the issuing port one cycle after its grant.
// Optional macro PRAM_ARB_BOUNDS_CHECK_EN: out-of-range word indices are
// granted but suppressed at the RAM and answered with ERR.
module pram_arbiter
    import pram_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int BYTE_WIDTH = 8,
    parameter  int ADDR_WIDTH = 32,
    parameter  int SRAM_DEPTH = 1024,
    localparam int N_COLS     = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_P0_REQ,
    input  logic [ADDR_WIDTH-1:0] i_P0_ADDR,
    input  logic [DATA_WIDTH-1:0] i_P0_WDATA,
    input  logic [N_COLS-1:0]     i_P0_WE,
    output logic                  o_P0_GNT,
    output logic [DATA_WIDTH-1:0] o_P0_RDATA,
    output logic                  o_P0_RVALID,
    output logic                  o_P0_ERR,
    input  logic                  i_P1_REQ,
    input  logic [ADDR_WIDTH-1:0] i_P1_ADDR,
    input  logic [DATA_WIDTH-1:0] i_P1_WDATA,
    input  logic [N_COLS-1:0]     i_P1_WE,
    output logic                  o_P1_GNT,
    output logic [DATA_WIDTH-1:0] o_P1_RDATA,
    output logic                  o_P1_RVALID,
    output logic                  o_P1_ERR,
    output logic                  o_MEM_CE,
    output logic [ADDR_WIDTH-1:0] o_MEM_ADDR,
    output logic [DATA_WIDTH-1:0] o_MEM_WDATA,
    output logic [N_COLS-1:0]     o_MEM_WE,
    input  logic [DATA_WIDTH-1:0] i_MEM_RDATA,
    input  logic                  i_MEM_VALID
);

    localparam int unsigned WORD_SHIFT = word_shift(n_cols(DATA_WIDTH, BYTE_WIDTH));

    logic [1:0]            gnt;
    logic                  any_gnt;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [N_COLS-1:0]     sel_we;
    logic                  oob;
    logic                  pend;
    port_id_t              own;
    logic                  resp_err;
    logic                  chk_en;

    // Requests are masked during reset so no output rises before release.
    pram_arb_rr u_rr (
        .i_CLK (i_CLK),
        .i_RST (i_RST),
        .i_REQ ({i_P1_REQ, i_P0_REQ} & {2{~i_RST}}),
        .o_GNT (gnt)
    );

    assign o_P0_GNT = gnt[0];
    assign o_P1_GNT = gnt[1];

    // Select the granted port's access; P0 is the idle default.
    always_comb begin
        any_gnt   = |gnt;
        sel_addr  = gnt[1] ? i_P1_ADDR  : i_P0_ADDR;
        sel_wdata = gnt[1] ? i_P1_WDATA : i_P0_WDATA;
        sel_we    = gnt[1] ? i_P1_WE    : i_P0_WE;
        word_idx  = sel_addr >> WORD_SHIFT;
    end

`ifdef PRAM_ARB_BOUNDS_CHECK_EN
    localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(SRAM_DEPTH);
    logic perr;

    assign oob      = word_idx >= DEPTH_W;
    assign resp_err = pend & perr;

    // Remember whether the access now in flight was suppressed as out of range.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            perr <= 1'b0;
        end else begin
            perr <= any_gnt & oob;
        end
    end
`else
    assign oob      = 1'b0;
    assign resp_err = 1'b0;
`endif

    // Drive the RAM; an out-of-range grant still consumes the slot but never reaches the RAM.
    always_comb begin
        o_MEM_CE    = 1'b0;
        o_MEM_WE    = '0;
        o_MEM_ADDR  = '0;
        o_MEM_WDATA = '0;
        if (!i_RST) begin
            o_MEM_ADDR  = word_idx;
            o_MEM_WDATA = sel_wdata;
            if (any_gnt && !oob) begin
                o_MEM_CE = 1'b1;
                o_MEM_WE = sel_we;
            end
        end
    end

    // Track the single outstanding response and who owns it.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            pend <= 1'b0;
            own  <= PORT_IF;
        end else begin
            pend <= any_gnt;
            if (any_gnt) begin
                own <= gnt[1] ? PORT_LS : PORT_IF;
            end
        end
    end

    // Route the response to its owner; the other port sees zeros.
    always_comb begin
        o_P0_RVALID = 1'b0;
        o_P0_RDATA  = '0;
        o_P0_ERR    = 1'b0;
        o_P1_RVALID = 1'b0;
        o_P1_RDATA  = '0;
        o_P1_ERR    = 1'b0;
        if (pend) begin
            if (own == PORT_IF) begin
                o_P0_RVALID = 1'b1;
                o_P0_RDATA  = resp_err ? '0 : i_MEM_RDATA;
                o_P0_ERR    = resp_err;
            end else begin
                o_P1_RVALID = 1'b1;
                o_P1_RDATA  = resp_err ? '0 : i_MEM_RDATA;
                o_P1_ERR    = resp_err;
            end
        end
    end

    // Skip the first edge after reset so a RAM valid from a dropped access is ignored.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            chk_en <= 1'b0;
        end else begin
            chk_en <= 1'b1;
        end
    end

    a_cfg_ok: assert property (@(posedge i_CLK)
        SRAM_DEPTH > 0 && (DATA_WIDTH % BYTE_WIDTH) == 0);

    a_pend_matches_ram: assert property (@(posedge i_CLK) disable iff (i_RST || !chk_en)
        (pend && !resp_err) == i_MEM_VALID);

endmodule

// File: tb/tb_pram_arbiter.sv
// Bench for pram_arbiter: a behavioural RAM, a scoreboard model of the
// arbitration/response rules checked every cycle, and directed scenarios
// with hand-computed expectations.
module tb_pram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p1_req;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic [3:0]  p0_we, p1_we;
    logic        gnt0, gnt1, rv0, rv1, err0, err1;
    logic [31:0] rd0, rd1;
    logic        ce;
    logic [31:0] maddr, mwdata;
    logic [3:0]  mwe;
    logic [31:0] mrdata = 32'h0;
    logic        mvalid = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pram_arbiter #(
        .DATA_WIDTH (32),
        .BYTE_WIDTH (8),
        .ADDR_WIDTH (32),
        .SRAM_DEPTH (1024)
    ) dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_P0_REQ    (p0_req),
        .i_P0_ADDR   (p0_addr),
        .i_P0_WDATA  (p0_wdata),
        .i_P0_WE     (p0_we),
        .o_P0_GNT    (gnt0),
        .o_P0_RDATA  (rd0),
        .o_P0_RVALID (rv0),
        .o_P0_ERR    (err0),
        .i_P1_REQ    (p1_req),
        .i_P1_ADDR   (p1_addr),
        .i_P1_WDATA  (p1_wdata),
        .i_P1_WE     (p1_we),
        .o_P1_GNT    (gnt1),
        .o_P1_RDATA  (rd1),
        .o_P1_RVALID (rv1),
        .o_P1_ERR    (err1),
        .o_MEM_CE    (ce),
        .o_MEM_ADDR  (maddr),
        .o_MEM_WDATA (mwdata),
        .o_MEM_WE    (mwe),
        .i_MEM_RDATA (mrdata),
        .i_MEM_VALID (mvalid)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Read-first, byte-writable RAM with one cycle of latency; filled at the first edge.
    logic [31:0] ram [1024];
    logic        ram_fill = 1'b1;
    always @(posedge clk) begin
        if (ram_fill) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 32'hDEADBEEF;
            ram_fill <= 1'b0;
        end else begin
            mvalid <= ce;
            if (ce) begin
                mrdata <= ram[maddr[9:0]];
                for (int b = 0; b < 4; b++)
                    if (mwe[b]) ram[maddr[9:0]][8*b +: 8] <= mwdata[8*b +: 8];
            end
        end
    end

    // Scoreboard: golden memory, last-winner and one expected response.
    logic [31:0] gmem [1024];
    bit          gfill = 1'b0;
    int          m_last = 1;
    bit          m_pend = 1'b0;
    int          m_own = 0;
    logic [31:0] m_data = 32'h0;
    bit          m_err = 1'b0;

    always @(negedge clk) begin
        bit          e_g0, e_g1, e_oob;
        logic [31:0] a, wd, idx;
        logic [3:0]  we;
        if (!gfill) begin
            for (int i = 0; i < 1024; i++) gmem[i] = 32'hDEADBEEF;
            gfill = 1'b1;
        end
        if (rst) begin
            chk("rst_gnt", {gnt0, gnt1}, 2'b00);
            chk("rst_rvalid", {rv0, rv1}, 2'b00);
            chk("rst_rdata", {rd0, rd1}, 64'h0);
            chk("rst_err", {err0, err1}, 2'b00);
            chk("rst_mem", {ce, mwe, maddr, mwdata}, '0);
            m_last = 1;
            m_pend = 1'b0;
        end else begin
            e_g0 = p0_req && (!p1_req || m_last == 1);
            e_g1 = p1_req && !e_g0;
            a    = e_g1 ? p1_addr  : p0_addr;
            wd   = e_g1 ? p1_wdata : p0_wdata;
            we   = e_g1 ? p1_we    : p0_we;
            idx  = a / 4;
`ifdef PRAM_ARB_BOUNDS_CHECK_EN
            e_oob = idx >= 1024;
`else
            e_oob = 1'b0;
`endif
            chk("m_gnt0", gnt0, e_g0);
            chk("m_gnt1", gnt1, e_g1);
            chk("m_ce", ce, (e_g0 || e_g1) && !e_oob);
            chk("m_we", mwe, ((e_g0 || e_g1) && !e_oob) ? we : 4'h0);
            if (e_g0 || e_g1) begin
                chk("m_addr", maddr, idx);
                chk("m_wdata", mwdata, wd);
            end
            chk("m_rv0", rv0, m_pend && m_own == 0);
            chk("m_rv1", rv1, m_pend && m_own == 1);
            chk("m_rd0", rd0, (m_pend && m_own == 0) ? m_data : 32'h0);
            chk("m_rd1", rd1, (m_pend && m_own == 1) ? m_data : 32'h0);
            chk("m_err0", err0, m_pend && m_own == 0 && m_err);
            chk("m_err1", err1, m_pend && m_own == 1 && m_err);
            m_pend = e_g0 || e_g1;
            if (m_pend) begin
                m_own  = e_g1 ? 1 : 0;
                m_last = m_own;
                m_err  = e_oob;
                if (e_oob) begin
                    m_data = 32'h0;
                end else begin
                    m_data = gmem[idx % 1024];
                    for (int b = 0; b < 4; b++)
                        if (we[b]) gmem[idx % 1024][8*b +: 8] = wd[8*b +: 8];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_req = 0; p0_addr = 0; p0_wdata = 0; p0_we = 0;
        p1_req = 0; p1_addr = 0; p1_wdata = 0; p1_we = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        repeat (3) step();
        rst = 0;
    endtask

    initial begin
        bit g0, g1;
        rst = 1;
        idle_inputs();
        do_reset();

        // Single P0 read at 0x10.
        p0_req = 1; p0_addr = 32'h10;
        @(negedge clk);
        chk("t1_gnt0", gnt0, 1'b1);
        chk("t1_mem_addr", maddr, 32'd4);
        step();
        p0_req = 0;
        @(negedge clk);
        chk("t1_rvalid0", rv0, 1'b1);
        chk("t1_rdata0", rd0, 32'hDEADBEEF);
        chk("t1_rvalid1", rv1, 1'b0);
        step();

        // P1 partial write, then P0 reads it back.
        p1_req = 1; p1_addr = 32'h20; p1_wdata = 32'h12345678; p1_we = 4'b0011;
        @(negedge clk);
        chk("t2_gnt1", gnt1, 1'b1);
        step();
        p1_req = 0; p1_we = 0;
        p0_req = 1; p0_addr = 32'h20;
        @(negedge clk);
        chk("t2_rvalid1", rv1, 1'b1);
        chk("t2_rdata1", rd1, 32'hDEADBEEF);
        chk("t2_gnt0", gnt0, 1'b1);
        step();
        p0_req = 0;
        @(negedge clk);
        chk("t2_rdata0", rd0, 32'hDEAD5678);
        step();

        // Continuous contention from reset: P0 first, then alternate.
        do_reset();
        p0_req = 1; p0_addr = 32'h40;
        p1_req = 1; p1_addr = 32'h84;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t3_gnt0", gnt0, (i % 2) == 0);
            chk("t3_gnt1", gnt1, (i % 2) == 1);
            step();
        end
        p0_req = 0; p1_req = 0;
        @(negedge clk);
        chk("t3_last_rvalid1", rv1, 1'b1);
        step();

        // Reset during the response cycle of a P1 access drops it.
        p1_req = 1; p1_addr = 32'h30;
        @(negedge clk);
        chk("t4_gnt1", gnt1, 1'b1);
        step();
        p1_req = 0;
        rst = 1;
        @(negedge clk);
        chk("t4_rvalid1", rv1, 1'b0);
        chk("t4_ce", ce, 1'b0);
        repeat (2) step();
        rst = 0;
        p0_req = 1; p0_addr = 32'h44;
        p1_req = 1; p1_addr = 32'h48;
        @(negedge clk);
        chk("t4_post_gnt0", gnt0, 1'b1);
        chk("t4_post_gnt1", gnt1, 1'b0);
        step();
        p0_req = 0; p1_req = 0;
        step();

`ifdef PRAM_ARB_BOUNDS_CHECK_EN
        // Out-of-range P1 read: granted, kept off the RAM, answered with ERR.
        p1_req = 1; p1_addr = 32'h1000;
        @(negedge clk);
        chk("t5_gnt1", gnt1, 1'b1);
        chk("t5_ce", ce, 1'b0);
        step();
        p1_req = 0;
        @(negedge clk);
        chk("t5_rvalid1", rv1, 1'b1);
        chk("t5_err1", err1, 1'b1);
        chk("t5_rdata1", rd1, 32'h0);
        step();
`endif

        // Twenty cycles of contention with fresh accesses after each grant.
        p0_req = 1; p0_addr = 32'h100; p0_wdata = 32'hA5A5A5A5; p0_we = 4'b1111;
        p1_req = 1; p1_addr = 32'h102; p1_wdata = 32'h0; p1_we = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            g0 = gnt0;
            g1 = gnt1;
            step();
            if (g0) begin
                p0_addr  = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
                p0_wdata = $urandom;
                p0_we    = $urandom_range(0, 1) ? 4'($urandom) : 4'b0000;
            end
            if (g1) begin
                p1_addr  = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
                p1_wdata = $urandom;
                p1_we    = $urandom_range(0, 1) ? 4'($urandom) : 4'b0000;
            end
        end
        p0_req = 0; p1_req = 0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
